// File: rtl/stream_reduce_unit.sv
// Sequential bitwise reduction unit: collects PORT_NUM operands over a valid/ready
// stream, folds them with AND/OR/XOR/XNOR and presents the vector and scalar result.
module stream_reduce_unit #(
    parameter int PORT_NUM = 8,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_bit,
    output logic             busy
);

    localparam int CNT_W = $clog2(PORT_NUM + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PORT_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_r;

    // XNOR folds like XOR; the inversion is applied only when presenting the result.
    function automatic logic [WIDTH-1:0] fold(input logic [1:0] m,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (m)
            2'b00:   fold = a & b;
            2'b01:   fold = a | b;
            default: fold = a ^ b;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            mode_r    <= 2'b00;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc    <= in_data;
                        mode_r <= mode;
                        cnt    <= CNT_W'(1);
                        busy   <= 1'b1;
                        if (PORT_NUM == 1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= fold(mode_r, acc, in_data);
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Results come purely from registered state, so nothing ripples from in_data.
    always_comb begin
        out_vec = acc;
        out_bit = 1'b0;
        case (mode_r)
            2'b00: out_bit = &acc;
            2'b01: out_bit = |acc;
            2'b10: out_bit = ^acc;
            2'b11: begin
                out_vec = ~acc;
                out_bit = ~(^acc);
            end
            default: out_bit = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_stream_reduce_unit.sv
// Directed bench for stream_reduce_unit: an 8x7-bit instance for the main scenarios
// and a 1x4-bit instance for the single-operand corner.
module tb_stream_reduce_unit;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_vec;
    logic       out_bit;
    logic       busy;

    logic [1:0] mode1;
    logic       in_valid1;
    logic       in_ready1;
    logic [3:0] in_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic [3:0] out_vec1;
    logic       out_bit1;
    logic       busy1;

    int total;
    int bad;
    logic [6:0] grp [8];

    stream_reduce_unit #(.PORT_NUM(8), .WIDTH(7)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_bit(out_bit), .busy(busy)
    );

    stream_reduce_unit #(.PORT_NUM(1), .WIDTH(4)) dut1 (
        .clk(clk), .reset(reset), .mode(mode1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_vec(out_vec1), .out_bit(out_bit1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operand and hold it until accepted; a stuck in_ready counts as a failure.
    task automatic push(input logic [6:0] d, input logic [1:0] m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) begin
            total++; bad++;
            $display("[TB] FAIL push_timeout in_ready=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic feed(input int first, input int last, input logic [1:0] m,
                        input int gap, input bit toggle);
        for (int i = first; i < last; i++) begin
            push(grp[i], (i == 0) ? m : (toggle ? ~m : m));
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
        total++; if (out_vec !== 7'h00)  begin bad++; $display("[TB] FAIL rst_out_vec got=%h want=00", out_vec); end
        total++; if (out_bit !== 1'b0)   begin bad++; $display("[TB] FAIL rst_out_bit got=%b want=0", out_bit); end
    endtask

    task automatic test_and;
        for (int i = 0; i < 8; i++) grp[i] = 7'h7F;
        feed(0, 7, 2'b00, 0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL and_early_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b1)      begin bad++; $display("[TB] FAIL and_busy got=%b want=1", busy); end
        feed(7, 8, 2'b00, 0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL and_latency got=%b want=1", out_valid); end
        total++; if (out_vec !== 7'h7F)  begin bad++; $display("[TB] FAIL and_vec got=%h want=7f", out_vec); end
        total++; if (out_bit !== 1'b1)   begin bad++; $display("[TB] FAIL and_bit got=%b want=1", out_bit); end
        release_result();
        grp[4] = 7'h7E;
        feed(0, 8, 2'b00, 0, 1'b0);
        total++; if (out_vec !== 7'h7E)  begin bad++; $display("[TB] FAIL and2_vec got=%h want=7e", out_vec); end
        total++; if (out_bit !== 1'b0)   begin bad++; $display("[TB] FAIL and2_bit got=%b want=0", out_bit); end
        release_result();
    endtask

    task automatic test_or;
        for (int i = 0; i < 8; i++) grp[i] = 7'h00;
        grp[7] = 7'h01;
        feed(0, 8, 2'b01, 0, 1'b0);
        total++; if (out_vec !== 7'h01) begin bad++; $display("[TB] FAIL or_vec got=%h want=01", out_vec); end
        total++; if (out_bit !== 1'b1)  begin bad++; $display("[TB] FAIL or_bit got=%b want=1", out_bit); end
        release_result();
        grp[7] = 7'h00;
        feed(0, 8, 2'b01, 0, 1'b0);
        total++; if (out_vec !== 7'h00) begin bad++; $display("[TB] FAIL or0_vec got=%h want=00", out_vec); end
        total++; if (out_bit !== 1'b0)  begin bad++; $display("[TB] FAIL or0_bit got=%b want=0", out_bit); end
        release_result();
    endtask

    task automatic load_onehot;
        grp[0] = 7'h01; grp[1] = 7'h02; grp[2] = 7'h04; grp[3] = 7'h08;
        grp[4] = 7'h10; grp[5] = 7'h20; grp[6] = 7'h40; grp[7] = 7'h00;
    endtask

    task automatic test_xor_xnor;
        load_onehot();
        feed(0, 8, 2'b10, 0, 1'b0);
        total++; if (out_vec !== 7'h7F) begin bad++; $display("[TB] FAIL xor_vec got=%h want=7f", out_vec); end
        total++; if (out_bit !== 1'b1)  begin bad++; $display("[TB] FAIL xor_bit got=%b want=1", out_bit); end
        release_result();
        feed(0, 8, 2'b11, 0, 1'b0);
        total++; if (out_vec !== 7'h00) begin bad++; $display("[TB] FAIL xnor_vec got=%h want=00", out_vec); end
        total++; if (out_bit !== 1'b0)  begin bad++; $display("[TB] FAIL xnor_bit got=%b want=0", out_bit); end
        release_result();
        feed(0, 8, 2'b10, 0, 1'b1);
        total++; if (out_vec !== 7'h7F) begin bad++; $display("[TB] FAIL toggle_vec got=%h want=7f", out_vec); end
        total++; if (out_bit !== 1'b1)  begin bad++; $display("[TB] FAIL toggle_bit got=%b want=1", out_bit); end
        release_result();
    endtask

    task automatic test_backpressure;
        load_onehot();
        feed(0, 8, 2'b10, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 7'h55;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b0)  begin bad++; $display("[TB] FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid c=%0d got=%b want=1", c, out_valid); end
            total++; if (out_vec !== 7'h7F)  begin bad++; $display("[TB] FAIL bp_vec c=%0d got=%h want=7f", c, out_vec); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL bp_release_busy got=%b want=0", busy); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL bp_stray_operand busy=%b want=0", busy); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL bp_idle_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid_group;
        for (int i = 0; i < 8; i++) grp[i] = 7'h00;
        feed(0, 3, 2'b01, 0, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'h00;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0)      begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        for (int i = 0; i < 8; i++) grp[i] = 7'h7F;
        feed(0, 7, 2'b00, 0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_early got=%b want=0", out_valid); end
        feed(7, 8, 2'b00, 0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_done got=%b want=1", out_valid); end
        total++; if (out_vec !== 7'h7F)  begin bad++; $display("[TB] FAIL midrst_vec got=%h want=7f", out_vec); end
        total++; if (out_bit !== 1'b1)   begin bad++; $display("[TB] FAIL midrst_bit got=%b want=1", out_bit); end
        release_result();
    endtask

    task automatic test_gaps;
        load_onehot();
        feed(0, 8, 2'b10, 2, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_valid got=%b want=1", out_valid); end
        total++; if (out_vec !== 7'h7F)  begin bad++; $display("[TB] FAIL gap_vec got=%h want=7f", out_vec); end
        total++; if (out_bit !== 1'b1)   begin bad++; $display("[TB] FAIL gap_bit got=%b want=1", out_bit); end
        release_result();
    endtask

    task automatic test_single_port;
        in_valid1 = 1'b1;
        in_data1  = 4'hA;
        mode1     = 2'b10;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        total++; if (out_valid1 !== 1'b1) begin bad++; $display("[TB] FAIL p1_valid got=%b want=1", out_valid1); end
        total++; if (in_ready1 !== 1'b0)  begin bad++; $display("[TB] FAIL p1_in_ready got=%b want=0", in_ready1); end
        total++; if (out_vec1 !== 4'hA)   begin bad++; $display("[TB] FAIL p1_vec got=%h want=a", out_vec1); end
        total++; if (out_bit1 !== 1'b0)   begin bad++; $display("[TB] FAIL p1_bit got=%b want=0", out_bit1); end
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("[TB] FAIL p1_release got=%b want=0", out_valid1); end
        total++; if (busy1 !== 1'b0)      begin bad++; $display("[TB] FAIL p1_busy got=%b want=0", busy1); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        mode       = 2'b00;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        mode1      = 2'b00;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
        test_reset();
        test_and();
        test_or();
        test_xor_xnor();
        test_backpressure();
        test_reset_mid_group();
        test_gaps();
        test_single_port();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_reduce_unit.md
Name: stream_reduce_unit

Overview:
- Parametrised, sequential successor to the fixed 8-port combinational reduction block.
- Accepts a group of PORT_NUM operands, WIDTH bits each, one per cycle over a valid/ready stream.
- Reduces the group bitwise across operands with a selectable operator (AND/OR/XOR/XNOR), then emits the per-bit result vector plus a single fully reduced bit over an output valid/ready handshake.
- Sits between an operand source (FIFO or bus slave) and a result consumer in the judge datapath.

Parameters:
- PORT_NUM, 8, operands per group; legal range is 1 or more.
- WIDTH, 8, operand and result-vector width in bits; legal range is 1 or more.
- CNT_W, $clog2(PORT_NUM+1), operand-counter width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  2  operator select: 00 AND, 01 OR, 10 XOR, 11 XNOR; sampled on the first operand of a group only.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  unit can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts the result.
- out_vec  output  WIDTH  bitwise reduction across all operands of the group.
- out_bit  output  1  full reduction of the whole group (all operands, all bits).
- busy  output  1  high when state is not IDLE.

Behaviour:
- Handshakes:
  - Input handshake = in_valid & in_ready at a rising edge.
  - Output handshake = out_valid & out_ready at a rising edge.
- Reset (reset=1 at an edge, any state):
  - state=IDLE, acc=0, cnt=0, mode_r=00.
  - out_valid=0, out_vec=0, out_bit=0, busy=0.
  - A partially accumulated group is discarded. An in_valid present during the reset cycle is not accepted.
- State machine IDLE / ACCUM / DONE:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On input handshake: acc<=in_data, mode_r<=mode, cnt<=1.
    - Next state is DONE if PORT_NUM==1, otherwise ACCUM.
  - ACCUM:
    - in_ready=1.
    - On input handshake: acc<=op(mode_r, acc, in_data), cnt<=cnt+1.
    - If cnt==PORT_NUM-1 at the handshake, next state is DONE.
    - Gaps in in_valid simply stall; there is no timeout.
  - DONE:
    - in_ready=0, out_valid=1.
    - out_vec and out_bit are held stable until the output handshake, then the state returns to IDLE.
    - in_valid while in DONE is ignored; no operand is consumed.
- Operators:
  - op is &, |, ^ for AND, OR, XOR. XNOR accumulates with ^.
  - out_vec: AND gives acc; OR gives acc; XOR gives acc; XNOR gives ~acc.
  - out_bit: AND gives &acc; OR gives |acc; XOR gives ^acc; XNOR gives ~(^acc).
  - out_vec and out_bit are driven from registered acc and mode_r only; no combinational path from in_data.
- mode changes after the first operand of a group have no effect on that group.
- Timing:
  - Latency: out_valid rises in the cycle after the edge that accepts the last operand.
  - Minimum group period is PORT_NUM+1 cycles, because the DONE cycle blocks input.
  - The next group's first operand is accepted no earlier than the edge after the output handshake.
- Width: all operations are WIDTH-bit with no extension; cnt never exceeds PORT_NUM.

Test Plan:
- WIDTH=7, PORT_NUM=8, mode=00: eight operands of 0x7F, out_ready=1 → out_valid one cycle after the 8th accept; out_vec=0x7F, out_bit=1. Repeat with the 5th operand 0x7E → out_vec=0x7E, out_bit=0.
- mode=01: operands 0x00 ×7 then 0x01 → out_vec=0x01, out_bit=1. All 0x00 → out_vec=0x00, out_bit=0.
- mode=10: operands 01,02,04,08,10,20,40,00 → out_vec=0x7F, out_bit=1. The same group with mode=11 → out_vec=0x00, out_bit=0. Toggling mode mid-group leaves the result unchanged.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and data 0x55 → in_ready=0 and outputs stable throughout. On release, exactly one handshake, IDLE next, and no stray operand is consumed.
- Reset mid-group: after 3 accepted operands, pulse reset for 1 cycle → out_valid=0, busy=0. A fresh group of 8 operands then yields the correct result using only those 8 operands.
- PORT_NUM=1, WIDTH=4: single operand 0xA with mode=10 → DONE the next cycle; out_vec=0xA, out_bit=0. in_valid gaps of 2 cycles between operands at PORT_NUM=8 give the same result as back-to-back operands.
